// File: rtl/pixel_cell_packer_if.sv
// Pixel-in / packed-cell-out handshake bundle for pixel_cell_packer.
// master: pixel source + cell consumer side; slave: the packer itself.
interface pixel_cell_packer_if;
  localparam int unsigned COLOR_W = 4;
  localparam int unsigned LINE_W  = 8;

  logic               in_valid;
  logic               in_ready;
  logic [COLOR_W-1:0] in_color;
  logic               out_valid;
  logic               out_ready;
  logic [LINE_W-1:0]  out_font_line;
  logic [LINE_W-1:0]  out_bg_fg;
  logic               out_lossy;

  modport master (
    output in_valid, in_color, out_ready,
    input  in_ready, out_valid, out_font_line, out_bg_fg, out_lossy
  );

  modport slave (
    input  in_valid, in_color, out_ready,
    output in_ready, out_valid, out_font_line, out_bg_fg, out_lossy
  );
endinterface

// File: rtl/pixel_cell_packer.sv
// pixel_cell_packer: packs 8 serial 4-bit colour indices into one text-mode
// cell (font line bitmap + bg/fg attribute byte). Pixel 0 lands in bit 7.
// Optional: define PACK_STATS_EN to build the saturating lossy-cell counter;
// otherwise stat_lossy_cnt is tied to zero.
module pixel_cell_packer #(
  parameter int unsigned STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              line_restart,
  pixel_cell_packer_if.slave bus,
  output logic [STAT_W-1:0] stat_lossy_cnt
);

  localparam int unsigned CNT_W   = 3;
  localparam int unsigned COLOR_W = 4;
  localparam int unsigned LINE_W  = 8;
  localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(LINE_W - 1);

  // Accumulator state for the group in progress
  logic [CNT_W-1:0]   cnt;
  logic [LINE_W-2:0]  bits;
  logic [COLOR_W-1:0] bg;
  logic [COLOR_W-1:0] fg;
  logic               fg_set;
  logic               lossy;

  // Output cell register
  logic               out_valid;
  logic [LINE_W-1:0]  out_font_line;
  logic [LINE_W-1:0]  out_bg_fg;
  logic               out_lossy;

  // Next-state of the accumulator for the pixel presented this cycle
  logic               pix_bit;
  logic [COLOR_W-1:0] bg_n;
  logic [COLOR_W-1:0] fg_n;
  logic               fg_set_n;
  logic               lossy_n;

  logic               in_ready_c;
  logic               accept;
  logic               complete;

  // Only the 8th pixel can stall; a restart blocks the pixel in its cycle
  assign in_ready_c = !line_restart &&
                      ((cnt != LAST_POS) || !out_valid || bus.out_ready);
  assign accept     = bus.in_valid && in_ready_c;
  assign complete   = accept && (cnt == LAST_POS);

  assign bus.in_ready      = in_ready_c;
  assign bus.out_valid     = out_valid;
  assign bus.out_font_line = out_font_line;
  assign bus.out_bg_fg     = out_bg_fg;
  assign bus.out_lossy     = out_lossy;

  // Classify the incoming pixel against the colours seen so far in the group
  always_comb begin
    pix_bit  = 1'b0;
    bg_n     = bg;
    fg_n     = fg;
    fg_set_n = fg_set;
    lossy_n  = lossy;
    if (cnt == '0) begin
      bg_n     = bus.in_color;
      fg_set_n = 1'b0;
      lossy_n  = 1'b0;
    end else if (bus.in_color == bg) begin
      pix_bit = 1'b0;
    end else if (!fg_set) begin
      fg_n     = bus.in_color;
      fg_set_n = 1'b1;
      pix_bit  = 1'b1;
    end else if (bus.in_color == fg) begin
      pix_bit = 1'b1;
    end else begin
      // third colour: rendered as background and flagged
      lossy_n = 1'b1;
    end
  end

  // Accumulator register: restart discards the partial group
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      bits   <= '0;
      bg     <= '0;
      fg     <= '0;
      fg_set <= 1'b0;
      lossy  <= 1'b0;
    end else if (line_restart) begin
      cnt    <= '0;
      bits   <= '0;
      bg     <= '0;
      fg     <= '0;
      fg_set <= 1'b0;
      lossy  <= 1'b0;
    end else if (accept) begin
      cnt    <= cnt + CNT_W'(1);
      bits   <= {bits[LINE_W-3:0], pix_bit};
      bg     <= bg_n;
      fg     <= fg_n;
      fg_set <= fg_set_n;
      lossy  <= lossy_n;
    end
  end

  // Output cell register: load on completion, hold until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_font_line <= '0;
      out_bg_fg     <= '0;
      out_lossy     <= 1'b0;
    end else if (complete) begin
      out_valid     <= 1'b1;
      out_font_line <= {bits, pix_bit};
      out_bg_fg     <= {bg_n, (fg_set_n ? fg_n : bg_n)};
      out_lossy     <= lossy_n;
    end else if (bus.out_ready) begin
      out_valid     <= 1'b0;
    end
  end

`ifdef PACK_STATS_EN
  logic [STAT_W-1:0] lossy_cnt;

  // Saturating count of lossy cells entering the output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lossy_cnt <= '0;
    end else if (complete && lossy_n && (lossy_cnt != '1)) begin
      lossy_cnt <= lossy_cnt + STAT_W'(1);
    end
  end

  assign stat_lossy_cnt = lossy_cnt;
`else
  assign stat_lossy_cnt = '0;
`endif

endmodule

// File: tb/tb_pixel_cell_packer.sv
// Testbench for pixel_cell_packer: directed pixel groups, a cell-level model
// compared every cycle, and literal expectations for the documented cases.
module tb_pixel_cell_packer;

  localparam int unsigned STAT_W = 16;

  logic              clk;
  logic              rst_n;
  logic              line_restart;
  logic [STAT_W-1:0] stat_lossy_cnt;

  pixel_cell_packer_if bus();

  pixel_cell_packer #(.STAT_W(STAT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .line_restart   (line_restart),
    .bus            (bus),
    .stat_lossy_cnt (stat_lossy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, wanted %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- cell-level model ----------------
  typedef struct packed {
    logic [7:0] font;
    logic [7:0] bgfg;
    logic       lossy;
  } cell_t;

  logic [3:0] grp[$];
  cell_t      pend[$];
  int         mdl_stat = 0;

  function automatic cell_t make_cell(input logic [3:0] p [8]);
    cell_t      c;
    logic [3:0] bgc, fgc;
    bit         has_fg;
    bit         seen[16];
    int         ndist;
    bgc = p[0]; fgc = p[0]; has_fg = 0; ndist = 0;
    foreach (seen[k]) seen[k] = 0;
    for (int i = 0; i < 8; i++) begin
      if (!seen[p[i]]) begin seen[p[i]] = 1; ndist++; end
      if (!has_fg && p[i] != bgc) begin fgc = p[i]; has_fg = 1; end
    end
    c.font = 8'h00;
    for (int i = 0; i < 8; i++)
      c.font[7-i] = has_fg && (p[i] == fgc);
    c.bgfg  = {bgc, fgc};
    c.lossy = (ndist > 2);
    return c;
  endfunction

  // Compare every cycle, then advance the model with this cycle's handshakes
  always @(negedge clk) begin
    if (!rst_n) begin
      grp.delete();
      pend.delete();
      mdl_stat = 0;
    end else begin
      chk("m_out_valid", {31'd0, bus.out_valid}, {31'd0, pend.size() != 0});
      chk("m_in_ready", {31'd0, bus.in_ready},
          {31'd0, !line_restart && (grp.size() != 7 || pend.size() == 0 || bus.out_ready)});
`ifdef PACK_STATS_EN
      chk("m_stat", 32'(stat_lossy_cnt), 32'(mdl_stat));
`else
      chk("m_stat", 32'(stat_lossy_cnt), 32'd0);
`endif
      if (pend.size() != 0) begin
        chk("m_font", {24'd0, bus.out_font_line}, {24'd0, pend[0].font});
        chk("m_bgfg", {24'd0, bus.out_bg_fg}, {24'd0, pend[0].bgfg});
        chk("m_lossy", {31'd0, bus.out_lossy}, {31'd0, pend[0].lossy});
      end
      if (bus.out_valid && bus.out_ready && pend.size() != 0) void'(pend.pop_front());
      if (line_restart) begin
        grp.delete();
      end else if (bus.in_valid && bus.in_ready) begin
        grp.push_back(bus.in_color);
        if (grp.size() == 8) begin
          logic [3:0] p [8];
          cell_t c;
          for (int i = 0; i < 8; i++) p[i] = grp[i];
          c = make_cell(p);
          pend.push_back(c);
          if (c.lossy && mdl_stat < (1 << STAT_W) - 1) mdl_stat++;
          grp.delete();
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [3:0] c);
    int  t;
    bit  acc;
    bus.in_valid = 1'b1;
    bus.in_color = c;
    t = 0;
    acc = 0;
    do begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!acc && t < 50);
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic send8(input logic [31:0] px);
    for (int i = 0; i < 8; i++) send(px[31-4*i -: 4]);
  endtask

  task automatic expect_cell(input string nm, input logic [7:0] f,
                             input logic [7:0] bf, input logic l);
    int t;
    t = 0;
    @(negedge clk);
    while (!bus.out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    chk({nm, "_font"}, {24'd0, bus.out_font_line}, {24'd0, f});
    chk({nm, "_bgfg"}, {24'd0, bus.out_bg_fg}, {24'd0, bf});
    chk({nm, "_lossy"}, {31'd0, bus.out_lossy}, {31'd0, l});
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    chk({nm, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    chk({nm, "_font"}, {24'd0, bus.out_font_line}, 32'd0);
    chk({nm, "_bgfg"}, {24'd0, bus.out_bg_fg}, 32'd0);
    chk({nm, "_lossy"}, {31'd0, bus.out_lossy}, 32'd0);
    chk({nm, "_stat"}, 32'(stat_lossy_cnt), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n         = 1'b0;
    line_restart  = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_color  = 4'h0;
    bus.out_ready = 1'b1;
    #22;
    chk_reset_vals("reset");
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single colour cell, consumed immediately
    send8(32'h1111_1111);
    expect_cell("mono", 8'h00, 8'h11, 1'b0);
    @(negedge clk);
    chk("mono_one_cycle", {31'd0, bus.out_valid}, 32'd0);
    @(posedge clk);
    #1;

    // alternating two colours
    send8(32'h0F0F_0F0F);
    expect_cell("alt", 8'h55, 8'h0F, 1'b0);

    // three colours: third rendered as bg, flagged lossy
    send8(32'h2277_3272);
    expect_cell("lossy", 8'h32, 8'h27, 1'b1);
`ifdef PACK_STATS_EN
    chk("lossy_stat", 32'(stat_lossy_cnt), 32'd1);
`else
    chk("lossy_stat", 32'(stat_lossy_cnt), 32'd0);
`endif

    // back-pressure: second cell's 8th pixel stalls while cell 1 is held
    bus.out_ready = 1'b0;
    send8(32'h3333_4444);
    for (int i = 0; i < 7; i++) send(4'(i[0] ? 4'h9 : 4'h6) == 4'h0 ? 4'h0 :
                                     (i == 4 || i == 5) ? 4'h9 : (i[0] ? 4'h9 : 4'h6));
    bus.in_valid = 1'b1;
    bus.in_color = 4'h6;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("stall_hold_font", {24'd0, bus.out_font_line}, 32'h0F);
      chk("stall_hold_bgfg", {24'd0, bus.out_bg_fg}, 32'h34);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(4'h6);
    expect_cell("stall_cell2", 8'h5C, 8'h69, 1'b0);

    // restart discards the partial group; pixel in the restart cycle dropped
    send(4'h5); send(4'h5); send(4'h5);
    line_restart = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_color = 4'h5;
    @(negedge clk);
    chk("restart_in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk);
    #1;
    line_restart = 1'b0;
    bus.in_valid = 1'b0;
    send8(32'hABAB_ABAB);
    expect_cell("restart", 8'h55, 8'hAB, 1'b0);

    // async reset with a pending cell and a half-built group
    bus.out_ready = 1'b0;
    send8(32'h1212_1212);
    expect_cell("pre_reset", 8'h55, 8'h12, 1'b0);
    send(4'h3); send(4'h3); send(4'h3); send(4'h3);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async_reset");
    @(negedge clk);
    #2 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 7; i++) send(4'h8);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_reset_no_cell", {31'd0, bus.out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    send(4'hC);
    expect_cell("post_reset", 8'h01, 8'h8C, 1'b0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, wanted completion");
    $fatal(1, "timeout");
  end

endmodule
